// File: rtl/sr_latch_pkg.sv
// Shared constants for the SR latch driver: op encodings, FSM state encoding,
// counter width and the readback error rule.
package sr_latch_pkg;

  localparam int CNT_W = 8;

  localparam logic [1:0] OP_READ    = 2'b00;
  localparam logic [1:0] OP_SET     = 2'b01;
  localparam logic [1:0] OP_RESET   = 2'b10;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_PULSE  = 2'd1;
  localparam state_t ST_SETTLE = 2'd2;
  localparam state_t ST_RESP   = 2'd3;

  // A healthy latch has complementary outputs and Q matching the last write.
  function automatic logic sample_err(input logic [1:0] op, input logic q, input logic qbar);
    return (q == qbar) ||
           ((op == OP_SET) && (q != 1'b1)) ||
           ((op == OP_RESET) && (q != 1'b0));
  endfunction

endpackage

// File: rtl/sr_pulse_timer.sv
// Loadable 8-bit down-counter; done is high in the last cycle of a loaded interval.
module sr_pulse_timer
  import sr_latch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/sr_latch_driver.sv
// Drives S/R pulses into an external SR latch, waits to settle, samples Q/Qbar and reports.
// Optional err_sticky output enabled by SR_LATCH_DRIVER_STICKY_ERR_EN.
module sr_latch_driver
  import sr_latch_pkg::*;
#(
  parameter int PULSE_CYCLES  = 1,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  output logic       latch_S,
  output logic       latch_R,
  input  logic       latch_Q,
  input  logic       latch_Qbar,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_data,
  output logic       rsp_err
`ifdef SR_LATCH_DRIVER_STICKY_ERR_EN
  ,
  output logic       err_sticky
`endif
);

  localparam logic [CNT_W-1:0] PULSE_LD  = CNT_W'(PULSE_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             latch_s_q, latch_s_d;
  logic             latch_r_q, latch_r_d;
  logic             rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_done;

  sr_pulse_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d     = req_op;
          tmr_load = 1'b1;
          case (req_op)
            OP_SET, OP_RESET: begin
              state_d = ST_PULSE;
              tmr_val = PULSE_LD;
            end
            OP_READ: begin
              state_d = ST_SETTLE;
              tmr_val = SETTLE_LD;
            end
            default: begin
              // ILLEGAL spends one cycle in SETTLE so the response lands one cycle after accept.
              state_d = ST_SETTLE;
              tmr_val = CNT_W'(1);
            end
          endcase
        end
      end
      ST_PULSE: begin
        if (tmr_done) begin
          state_d  = ST_SETTLE;
          tmr_load = 1'b1;
          tmr_val  = SETTLE_LD;
        end
      end
      ST_SETTLE: begin
        if (tmr_done) begin
          state_d  = ST_RESP;
          tmr_load = 1'b1;
          if (op_q == OP_ILLEGAL) begin
            rsp_data_d = 1'b0;
            rsp_err_d  = 1'b1;
          end else begin
            rsp_data_d = latch_Q;
            rsp_err_d  = sample_err(op_q, latch_Q, latch_Qbar);
          end
        end
      end
      default: begin
        if (rsp_ready) begin
          state_d  = ST_IDLE;
          tmr_load = 1'b1;
        end
      end
    endcase
    // Both drives decode the single registered op, so they are mutually exclusive.
    latch_s_d = (state_d == ST_PULSE) && (op_d == OP_SET);
    latch_r_d = (state_d == ST_PULSE) && (op_d == OP_RESET);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_READ;
      latch_s_q  <= 1'b0;
      latch_r_q  <= 1'b0;
      rsp_data_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      latch_s_q  <= latch_s_d;
      latch_r_q  <= latch_r_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign latch_S   = latch_s_q;
  assign latch_R   = latch_r_q;

`ifdef SR_LATCH_DRIVER_STICKY_ERR_EN
  logic err_sticky_q, err_sticky_d;

  always_comb begin
    err_sticky_d = err_sticky_q | (rsp_valid & rsp_err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky_q <= 1'b0;
    end else begin
      err_sticky_q <= err_sticky_d;
    end
  end

  assign err_sticky = err_sticky_q;
`endif

endmodule

// File: tb/tb_sr_latch_driver.sv
// Scoreboard bench: two driver instances (default timing and 3/2 timing) with latch models.
module tb_sr_latch_driver;
  import sr_latch_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic d;
    logic e;
    int   lat;
    int   acc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  // Instance A: default parameters
  logic       a_rst = 1'b1, a_req_valid = 1'b0, a_rsp_ready = 1'b1, a_stuck = 1'b0;
  logic [1:0] a_req_op = OP_READ;
  logic       a_req_ready, a_latch_S, a_latch_R, a_latch_Q, a_latch_Qbar;
  logic       a_rsp_valid, a_rsp_data, a_rsp_err, a_m = 1'b0;
  // Instance B: PULSE_CYCLES=3, SETTLE_CYCLES=2
  logic       b_rst = 1'b1, b_req_valid = 1'b0, b_rsp_ready = 1'b1;
  logic [1:0] b_req_op = OP_READ;
  logic       b_req_ready, b_latch_S, b_latch_R, b_latch_Q, b_latch_Qbar;
  logic       b_rsp_valid, b_rsp_data, b_rsp_err, b_m = 1'b0;
`ifdef SR_LATCH_DRIVER_STICKY_ERR_EN
  logic       a_err_sticky, b_err_sticky;
`endif

  // Latch models: Q follows the last pulse; A can be forced into a stuck Q=Qbar=1 fault.
  always @(posedge clk) begin
    if (a_latch_S) a_m <= 1'b1;
    else if (a_latch_R) a_m <= 1'b0;
    if (b_latch_S) b_m <= 1'b1;
    else if (b_latch_R) b_m <= 1'b0;
  end
  assign a_latch_Q    = a_stuck ? 1'b1 : a_m;
  assign a_latch_Qbar = a_stuck ? 1'b1 : ~a_m;
  assign b_latch_Q    = b_m;
  assign b_latch_Qbar = ~b_m;

  sr_latch_driver dut_a (
    .clk(clk), .rst(a_rst), .req_valid(a_req_valid), .req_ready(a_req_ready), .req_op(a_req_op),
    .latch_S(a_latch_S), .latch_R(a_latch_R), .latch_Q(a_latch_Q), .latch_Qbar(a_latch_Qbar),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_data(a_rsp_data), .rsp_err(a_rsp_err)
`ifdef SR_LATCH_DRIVER_STICKY_ERR_EN
    , .err_sticky(a_err_sticky)
`endif
  );

  sr_latch_driver #(.PULSE_CYCLES(3), .SETTLE_CYCLES(2)) dut_b (
    .clk(clk), .rst(b_rst), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_op(b_req_op),
    .latch_S(b_latch_S), .latch_R(b_latch_R), .latch_Q(b_latch_Q), .latch_Qbar(b_latch_Qbar),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data), .rsp_err(b_rsp_err)
`ifdef SR_LATCH_DRIVER_STICKY_ERR_EN
    , .err_sticky(b_err_sticky)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  int a_s_cnt = 0, a_r_cnt = 0, b_s_cnt = 0, b_r_cnt = 0;
  always @(negedge clk) begin
    if (a_latch_S) a_s_cnt++;
    if (a_latch_R) a_r_cnt++;
    if (b_latch_S) b_s_cnt++;
    if (b_latch_R) b_r_cnt++;
    assert (!(a_latch_S && a_latch_R)) else begin
      errors++;
      $display("FAIL sr_overlap_a actual=S1R1 expected=not both");
    end
    assert (!(b_latch_S && b_latch_R)) else begin
      errors++;
      $display("FAIL sr_overlap_b actual=S1R1 expected=not both");
    end
  end

  // Monitors: record first-valid cycle and values, check stability, pop on handshake.
  logic a_seen = 1'b0, a_fd, a_fe;
  int   a_fc;
  always @(negedge clk) begin
    if (a_rsp_valid) begin
      if (!a_seen) begin
        a_seen = 1'b1; a_fc = cyc; a_fd = a_rsp_data; a_fe = a_rsp_err;
      end else begin
        check("a_hold_data", a_rsp_data, a_fd);
        check("a_hold_err", a_rsp_err, a_fe);
      end
      if (a_rsp_ready) begin
        a_seen = 1'b0;
        if (qa.size() == 0) begin
          check("a_unexpected_rsp", 1, 0);
        end else begin
          exp_t x;
          x = qa.pop_front();
          check("a_rsp_data", a_fd, x.d);
          check("a_rsp_err", a_fe, x.e);
          check("a_latency", a_fc - x.acc, x.lat);
        end
      end
    end
  end

  logic b_seen = 1'b0, b_fd, b_fe;
  int   b_fc;
  always @(negedge clk) begin
    if (b_rsp_valid) begin
      if (!b_seen) begin
        b_seen = 1'b1; b_fc = cyc; b_fd = b_rsp_data; b_fe = b_rsp_err;
      end
      if (b_rsp_ready) begin
        b_seen = 1'b0;
        if (qb.size() == 0) begin
          check("b_unexpected_rsp", 1, 0);
        end else begin
          exp_t x;
          x = qb.pop_front();
          check("b_rsp_data", b_fd, x.d);
          check("b_rsp_err", b_fe, x.e);
          check("b_latency", b_fc - x.acc, x.lat);
        end
      end
    end
  end

  task automatic issue_a(input logic [1:0] op, input logic d, input logic e, input int lat);
    exp_t x;
    @(negedge clk);
    a_req_valid = 1'b1; a_req_op = op;
    check("a_ready_at_accept", a_req_ready, 1);
    @(posedge clk); #1;
    x.d = d; x.e = e; x.lat = lat; x.acc = cyc;
    qa.push_back(x);
    a_req_valid = 1'b0;
  endtask

  task automatic issue_b(input logic [1:0] op, input logic d, input logic e, input int lat);
    exp_t x;
    @(negedge clk);
    b_req_valid = 1'b1; b_req_op = op;
    check("b_ready_at_accept", b_req_ready, 1);
    @(posedge clk); #1;
    x.d = d; x.e = e; x.lat = lat; x.acc = cyc;
    qb.push_back(x);
    b_req_valid = 1'b0;
  endtask

  task automatic drain_a(input string name);
    int n = 0;
    while (qa.size() != 0 && n < 50) begin
      @(posedge clk); n++;
    end
    @(posedge clk); #1;
    check(name, qa.size(), 0);
  endtask

  task automatic drain_b(input string name);
    int n = 0;
    while (qb.size() != 0 && n < 50) begin
      @(posedge clk); n++;
    end
    @(posedge clk); #1;
    check(name, qb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    a_rst = 1'b0; b_rst = 1'b0;
    check("rst_a_req_ready", a_req_ready, 1);
    check("rst_a_latch_S", a_latch_S, 0);
    check("rst_a_latch_R", a_latch_R, 0);
    check("rst_a_rsp_valid", a_rsp_valid, 0);
    check("rst_a_rsp_data", a_rsp_data, 0);
    check("rst_a_rsp_err", a_rsp_err, 0);
    check("rst_b_req_ready", b_req_ready, 1);
`ifdef SR_LATCH_DRIVER_STICKY_ERR_EN
    check("rst_a_sticky", a_err_sticky, 0);
`endif

    // SET with defaults
    a_s_cnt = 0; a_r_cnt = 0;
    issue_a(OP_SET, 1'b1, 1'b0, 2);
    drain_a("a_set_done");
    check("a_set_s_cycles", a_s_cnt, 1);
    check("a_set_r_cycles", a_r_cnt, 0);

    // READ of a healthy latch holding 1
    issue_a(OP_READ, 1'b1, 1'b0, 1);
    drain_a("a_read1_done");

    // RESET with defaults
    a_s_cnt = 0; a_r_cnt = 0;
    issue_a(OP_RESET, 1'b0, 1'b0, 2);
    drain_a("a_reset_done");
    check("a_reset_s_cycles", a_s_cnt, 0);
    check("a_reset_r_cycles", a_r_cnt, 1);

    // ILLEGAL op: error response, no latch activity
    a_s_cnt = 0; a_r_cnt = 0;
    issue_a(OP_ILLEGAL, 1'b0, 1'b1, 1);
    drain_a("a_illegal_done");
    check("a_illegal_s_cycles", a_s_cnt, 0);
    check("a_illegal_r_cycles", a_r_cnt, 0);
`ifdef SR_LATCH_DRIVER_STICKY_ERR_EN
    check("a_sticky_after_illegal", a_err_sticky, 1);
`endif

    // Stuck latch on READ
    a_stuck = 1'b1;
    issue_a(OP_READ, 1'b1, 1'b1, 1);
    drain_a("a_stuck_done");
    a_stuck = 1'b0;

    // Backpressure: rsp_ready low for 4 cycles with a competing request
    a_s_cnt = 0; a_r_cnt = 0;
    a_rsp_ready = 1'b0;
    issue_a(OP_READ, 1'b0, 1'b0, 1);
    begin
      int n = 0;
      while (!a_rsp_valid && n < 20) begin
        @(posedge clk); #1; n++;
      end
    end
    check("a_stall_rsp_seen", a_rsp_valid, 1);
    @(negedge clk);
    a_req_valid = 1'b1; a_req_op = OP_SET;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("a_stall_req_ready", a_req_ready, 0);
      check("a_stall_rsp_valid", a_rsp_valid, 1);
    end
    a_req_valid = 1'b0;
    a_rsp_ready = 1'b1;
    drain_a("a_stall_done");
    repeat (3) @(posedge clk);
    #1;
    check("a_stall_no_extra_rsp", a_rsp_valid, 0);
    check("a_stall_req_ignored", a_s_cnt, 0);

    // Instance B: SET then RESET with 3-cycle pulse, 2-cycle settle
    b_s_cnt = 0; b_r_cnt = 0;
    issue_b(OP_SET, 1'b1, 1'b0, 5);
    drain_b("b_set_done");
    check("b_set_s_cycles", b_s_cnt, 3);
    b_s_cnt = 0; b_r_cnt = 0;
    issue_b(OP_RESET, 1'b0, 1'b0, 5);
    drain_b("b_reset_done");
    check("b_reset_r_cycles", b_r_cnt, 3);
    check("b_reset_s_cycles", b_s_cnt, 0);

    // Reset in the middle of a SET pulse on B
    @(negedge clk);
    b_req_valid = 1'b1; b_req_op = OP_SET;
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    check("b_midpulse_s_high", b_latch_S, 1);
    @(negedge clk);
    b_rst = 1'b1;
    @(posedge clk); #1;
    check("b_midpulse_s_dropped", b_latch_S, 0);
    check("b_midpulse_r_low", b_latch_R, 0);
    @(negedge clk);
    b_rst = 1'b0;
    check("b_midpulse_ready", b_req_ready, 1);
    repeat (8) @(posedge clk);
    #1;
    check("b_midpulse_no_rsp", b_rsp_valid, 0);
    check("b_midpulse_s_idle", b_latch_S, 0);

`ifdef SR_LATCH_DRIVER_STICKY_ERR_EN
    check("a_sticky_held", a_err_sticky, 1);
    @(negedge clk);
    a_rst = 1'b1;
    @(posedge clk); #1;
    a_rst = 1'b0;
    check("a_sticky_cleared", a_err_sticky, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sr_latch_driver.md
SR_LATCH_DRIVER -- requirements
Module: sr_latch_driver

Interface
REQ-001 Parameter PULSE_CYCLES, default 1, SHALL set the number of cycles an S or R pulse is held high; legal range is 1..255.
REQ-002 Parameter SETTLE_CYCLES, default 1, SHALL set the number of cycles with S=R=0 before Q/Qbar are sampled; legal range is 1..255.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  request offered.
REQ-006 req_ready  output  1  driver can accept a request.
REQ-007 req_op  input  2  operation: 00 READ, 01 SET, 10 RESET, 11 ILLEGAL.
REQ-008 latch_S  output  1  set drive to the external latch.
REQ-009 latch_R  output  1  reset drive to the external latch.
REQ-010 latch_Q  input  1  latch Q readback.
REQ-011 latch_Qbar  input  1  latch Qbar readback.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  consumer accepts the response.
REQ-014 rsp_data  output  1  sampled Q.
REQ-015 rsp_err  output  1  operation failed or was rejected.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, PULSE, SETTLE and RESP.
REQ-017 IDLE SHALL drive req_ready=1; every other state SHALL drive req_ready=0.
REQ-018 A request is accepted on a rising edge with req_valid && req_ready; req_op is registered at acceptance.
REQ-019 On accepting SET or RESET, the FSM SHALL enter PULSE and drive latch_S=1 (SET) or latch_R=1 (RESET) for exactly PULSE_CYCLES cycles.
REQ-020 On accepting READ, the FSM SHALL skip PULSE and enter SETTLE directly.
REQ-021 On accepting ILLEGAL, the FSM SHALL enter RESP on the next cycle with rsp_err=1, rsp_data=0, and SHALL NOT pulse the latch.
REQ-022 latch_S and latch_R SHALL never be 1 in the same cycle, under any input sequence.
REQ-023 latch_S and latch_R SHALL be registered outputs and SHALL be 0 outside PULSE.
REQ-024 SETTLE SHALL last exactly SETTLE_CYCLES cycles; Q/Qbar SHALL be sampled on its final edge, and the FSM SHALL then enter RESP.
REQ-025 The error rule, evaluated at the sample, SHALL set rsp_err=1 if any of the following hold:
- latch_Q==latch_Qbar;
- the op was SET and Q!=1;
- the op was RESET and Q!=0.
REQ-026 rsp_data SHALL be the sampled latch_Q.
REQ-027 Latency SHALL be deterministic: rsp_valid rises PULSE_CYCLES+SETTLE_CYCLES cycles after acceptance for SET/RESET, SETTLE_CYCLES cycles after for READ, and 1 cycle after for ILLEGAL.
REQ-028 In RESP, rsp_valid=1 and rsp_data/rsp_err SHALL hold stable until rsp_ready=1; the FSM SHALL return to IDLE on the edge where rsp_valid && rsp_ready.
REQ-029 req_valid SHALL be ignored outside IDLE; no request queueing.
REQ-030 Cycle counters SHALL be 8 bits, count down, and reload on every state entry.

Reset
REQ-031 When rst=1 on an edge, the driver SHALL set:
- state=IDLE;
- latch_S=0, latch_R=0;
- rsp_valid=0, rsp_data=0, rsp_err=0;
- counters=0.
REQ-032 req_ready SHALL be 1 in the first cycle after reset is released.
REQ-033 Reset during PULSE SHALL drop latch_S/latch_R to 0 on that same edge and discard the in-flight request without issuing a response.

Configuration
REQ-034 With SR_LATCH_DRIVER_STICKY_ERR_EN defined, an output err_sticky (1 bit) SHALL exist; it is set on any cycle with rsp_valid && rsp_err, and is cleared only by rst.
REQ-035 Without SR_LATCH_DRIVER_STICKY_ERR_EN, the err_sticky port and its register SHALL be absent, and behaviour SHALL be otherwise identical.

Structure
REQ-036 A shared package sr_latch_pkg SHALL hold:
- the op encoding constants (OP_READ, OP_SET, OP_RESET, OP_ILLEGAL);
- the FSM state typedef;
- the 8-bit counter width constant.
REQ-037 One sub-module, sr_pulse_timer, SHALL implement the loadable 8-bit down-counter with a done flag; it is instantiated once and shared by PULSE and SETTLE.

Verification
REQ-038 The bench SHALL cover these directed scenarios:
- SET with defaults, healthy latch model: S=1 for 1 cycle, R=0 throughout; rsp_valid 2 cycles after accept, rsp_data=1, rsp_err=0.
- RESET with PULSE_CYCLES=3, SETTLE_CYCLES=2: R=1 for exactly 3 cycles; rsp 5 cycles after accept, rsp_data=0, rsp_err=0.
- req_op=11: no S/R activity; rsp_valid next cycle with rsp_err=1; with the macro defined, err_sticky=1 until rst.
- Stuck latch (Q=Qbar=1) on READ: rsp_err=1, rsp_data=1.
- rsp_ready held 0 for 4 cycles: rsp_valid, rsp_data and rsp_err stable; req_ready=0; a concurrent req_valid is ignored.
- rst asserted mid-PULSE: S=0 on the same edge, no response; next cycle IDLE with req_ready=1.
REQ-039 An assertion SHALL check !(latch_S && latch_R) on every cycle of every scenario.
